// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, z = x * y, one Booth step per clock.
// Default build is signed two's-complement with WIDTH steps.
// Define BOOTH_UNSIGNED_EN for unsigned operands. Operands are zero-extended
// by one bit, and WIDTH+1 steps run.
module booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    // The accumulator is one bit wider than the operand, so the most negative multiplicand cannot overflow.
    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_reg;
    logic [AW-1:0]        m_reg;
    logic [AW-1:0]        a_reg;
    logic [QW-1:0]        q_reg;
    logic                 q_1_reg;
    logic [CW-1:0]        cnt_reg;
    logic [2*WIDTH-1:0]   z_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic [AW-1:0]        a_sum;
    logic [AW-1:0]        a_next;
    logic [QW-1:0]        q_next;
    logic                 q_1_next;
    logic [AW-1:0]        m_init;
    logic [QW-1:0]        q_init;
    logic [2*WIDTH-1:0]   product;

    // Operand extension at accept time, and product extraction from {A, Q}.
    always_comb begin
`ifdef BOOTH_UNSIGNED_EN
        m_init  = {1'b0, x};
        q_init  = {1'b0, y};
        product = {a_reg[WIDTH-2:0], q_reg};
`else
        m_init  = {x[WIDTH-1], x};
        q_init  = y;
        product = {a_reg[WIDTH-1:0], q_reg};
`endif
    end

    // One Booth step: add or subtract M by {Q[0], q_1}, then shift {A, Q, q_1} arithmetically right.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1_reg})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_next   = {a_sum[AW-1], a_sum[AW-1:1]};
        q_next   = {a_sum[0], q_reg[QW-1:1]};
        q_1_next = q_reg[0];
    end

    // Control FSM and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_1_reg   <= 1'b0;
            cnt_reg   <= '0;
            z_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        m_reg     <= m_init;
                        a_reg     <= '0;
                        q_reg     <= q_init;
                        q_1_reg   <= 1'b0;
                        cnt_reg   <= CW'(QW);
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    q_1_reg <= q_1_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    z_reg     <= product;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign z    = z_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier (WIDTH=4). Expected products are hand-computed.
module tb_booth_multiplier;

`ifdef BOOTH_UNSIGNED_EN
    localparam int STEPS = 5;
`else
    localparam int STEPS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] z;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    booth_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then check the busy window, the done pulse, the product, and the hold.
    task automatic run_mult(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                            input logic [7:0] exp);
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = 4'h0; y = 4'h0;
        for (int c = 1; c <= STEPS + 1; c++) begin
            if (c > 1) @(negedge clk);
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_nodone"}, {7'd0, done}, 8'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, {7'd0, done}, 8'd1);
        chk({tag, "_idle"}, {7'd0, busy}, 8'd0);
        chk({tag, "_z"}, z, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, {7'd0, done}, 8'd0);
        chk({tag, "_hold"}, z, exp);
        $display("txn %s x=%h y=%h z=%h expected=%h", tag, xv, yv, z, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x = 4'h0; y = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_z", z, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        rst = 1'b0;

`ifdef BOOTH_UNSIGNED_EN
        run_mult("u15x15", 4'd15, 4'd15, 8'hE1);
        run_mult("u8x2", 4'd8, 4'd2, 8'h10);
        run_mult("u3x3", 4'd3, 4'd3, 8'h09);
`else
        run_mult("5x5", 4'd5, 4'd5, 8'h19);
        run_mult("m3x7", 4'hD, 4'd7, 8'hEB);
        run_mult("7xm8", 4'd7, 4'h8, 8'hC8);
        run_mult("m8xm8", 4'h8, 4'h8, 8'h40);
        run_mult("0xm1", 4'd0, 4'hF, 8'h00);
        run_mult("m1xm1", 4'hF, 4'hF, 8'h01);
        run_mult("3xm2", 4'd3, 4'hE, 8'hFA);

        // A second start during the 2nd busy cycle must be ignored.
        @(negedge clk);
        x = 4'd5; y = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 4'd1; y = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int ndone = 0;
            logic [7:0] zdone = 8'h00;
            for (int c = 0; c < 16; c++) begin
                if (done) begin
                    ndone++;
                    zdone = z;
                end
                @(negedge clk);
            end
            chk("ignore_z", zdone, 8'h19);
            chk("ignore_ndone", 8'(ndone), 8'd1);
            chk("ignore_final_busy", {7'd0, busy}, 8'd0);
            $display("txn ignore_start dones=%0d z=%h expected=19", ndone, zdone);
        end
`endif

        // A reset during the 3rd RUN cycle discards the operation.
        @(negedge clk);
        x = 4'd3; y = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_z", z, 8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_done", {7'd0, done}, 8'd0);
        begin
            int ndone = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("midrst_nodone", 8'(ndone), 8'd0);
            $display("txn midrst z=%h busy=%b dones_after=%0d", z, busy, ndone);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stops a run that fails to reach the end of the sequence.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
